// File: rtl/serial_byte_feeder.sv
`default_nettype none
// ============================================================================
// serial_byte_feeder: LSB-first serial-to-word assembler feeding a DEPTH-entry
// FIFO that hands words to the detector over a ready/sent handshake.
// Revision 1.0
// ============================================================================
module serial_byte_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   frame_sync,
  input  logic                   ready,
  output logic [WIDTH-1:0]       data,
  output logic                   sent,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   busy,
  output logic                   overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;

  logic              push;
  logic [WIDTH-1:0]  push_word;
  logic              pop;
  logic              accept;

  // Assembler: frame_sync always restarts a word, even mid-word
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    push      = 1'b0;
    push_word = '0;
    if (bit_valid) begin
      if (frame_sync) begin
        shreg_d[0] = bit_in;
        bitcnt_d   = CW'(1);
        state_d    = SHIFT;
      end else if (state_q == SHIFT) begin
        shreg_d[bitcnt_q] = bit_in;
        if (bitcnt_q == LAST_BIT) begin
          push      = 1'b1;
          push_word = {bit_in, shreg_q[WIDTH-2:0]};
          bitcnt_d  = '0;
          state_d   = HUNT;
        end else begin
          bitcnt_d = bitcnt_q + CW'(1);
        end
      end
    end
  end

  // A pop on the same edge frees the slot, so a push while full is only dropped without one
  always_comb begin
    pop        = sent && ready;
    accept     = push && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & full & ~pop);
    if (accept) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign sent     = (count_q != '0);
  assign full     = (count_q == FULL_CNT);
  assign data     = sent ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign busy     = (state_q == SHIFT);
  assign overflow = overflow_q;

endmodule
`default_nettype wire
